// File: rtl/shr_host.sv
// shr_host: host-side driver for the minitest serial harness.
//
// Serializes a parallel stimulus word MSB-first onto di, pulses stb for one
// cycle so the harness latches its din register and loads its dout shift
// register, then deserializes DOUT_N bits of dut_do into a parallel result
// word held on out_data until accepted.
//
// Ports:
//   clk       - single rising-edge clock shared with the harness
//   rst_n     - synchronous active-low reset
//   in_valid  - stimulus word valid
//   in_ready  - host idle, stimulus can be accepted
//   in_data   - stimulus word, bit DIN_N-1 goes out first
//   out_valid - result word valid, held until out_ready
//   out_ready - consumer accepts the result
//   out_data  - captured result, first sampled bit in bit DOUT_N-1
//   di        - registered serial stimulus to the harness
//   stb       - registered capture strobe to the harness
//   dut_do    - serial result from the harness
//
// Latency from the accepting edge to out_valid is DIN_N+DOUT_N+1 edges.
// CNT_W must satisfy 2**CNT_W > max(DIN_N, DOUT_N).

module shr_host #(
    parameter int unsigned DIN_N  = 160,
    parameter int unsigned DOUT_N = 160,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_N-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_N-1:0] out_data,
    output logic              di,
    output logic              stb,
    input  logic              dut_do
);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StStrobe,
        StCapture,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] DinLast  = CNT_W'(DIN_N - 1);
    localparam logic [CNT_W-1:0] DoutLast = CNT_W'(DOUT_N - 1);

    state_e            state_q, state_d;
    logic [DIN_N-1:0]  tx_q, tx_d;
    logic [DOUT_N-1:0] rx_q, rx_d;
    logic [DOUT_N-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stb_q, stb_d;
    logic              out_valid_q, out_valid_d;

    // The tx register shifts left once per SHIFT cycle and di is its MSB.
    // After the last bit has been presented DIN_N shifts have emptied it, so
    // di reads 0 in every other state without extra gating.
    assign di        = tx_q[DIN_N-1];
    assign stb       = stb_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign in_ready  = (state_q == StIdle);

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        stb_d       = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    tx_d    = in_data;
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end

            StShift: begin
                tx_d = tx_q << 1;
                if (cnt_q == DinLast) begin
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Harness latches din and loads dout on the edge leaving here.
            StStrobe: begin
                cnt_d   = '0;
                state_d = StCapture;
            end

            StCapture: begin
                rx_d = (rx_q << 1) | DOUT_N'(dut_do);
                if (cnt_q == DoutLast) begin
                    out_data_d  = rx_d;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tx_q        <= '0;
            rx_q        <= '0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            stb_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
            stb_q       <= stb_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
